piso_tx_32bit: RTL and testbench



---
 rtl/siso_pkg.sv | 21 ++
 rtl/piso_bit_counter.sv | 35 +++
 rtl/piso_tx_32bit.sv | 151 +++++++++++++++
 tb/tb_piso_tx_32bit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared definitions for the SISO serial link: transmitter FSM states,
// default word width, line levels and the parity helper.
package siso_pkg;

    localparam int   SISO_WORD_W = 32;
    localparam logic LINE_IDLE   = 1'b0;
    localparam logic LINE_START  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_PAR   = 2'd3
    } piso_state_t;

    // Even parity over a zero-extended word; the extension bits do not alter the result.
    function automatic logic even_parity32(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module piso_bit_counter #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    logic [CW-1:0] count_r;
    logic          zero_s;

    assign zero_s = (count_r == {CW{1'b0}});

    // Count register: clear, load, or saturating decrement.
    always_ff @(posedge clk) begin
        if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && !zero_s) begin
            count_r <= count_r - CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign zero  = zero_s;

endmodule

// File: rtl/piso_tx_32bit.sv
// Parallel-in/serial-out frame transmitter: start bit, then the word MSB-first.
// Optional even-parity bit appended when PISO_TX_PARITY_EN is defined.
module piso_tx_32bit
    import siso_pkg::*;
#(
    parameter int WIDTH = SISO_WORD_W
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             so,
    output logic             busy,
    output logic             done
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    piso_state_t      state_r;
    piso_state_t      state_nxt_s;
    logic [WIDTH-1:0] shift_r;
    logic             so_r;
    logic             so_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             accept_s;
    logic             cnt_load_s;
    logic             cnt_dec_s;
    logic             shift_s;
    logic [CW-1:0]    cnt_s;
    logic             cnt_zero_s;
`ifdef PISO_TX_PARITY_EN
    logic             par_r;
`endif

    assign accept_s = (state_r == ST_IDLE) && load && !clear;

    piso_bit_counter #(
        .CW(CW)
    ) u_bit_counter (
        .clk      (clk),
        .clear    (clear),
        .load     (cnt_load_s),
        .load_val (CNT_LAST),
        .dec      (cnt_dec_s),
        .count    (cnt_s),
        .zero     (cnt_zero_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: state_nxt_s = ST_DATA;
            ST_DATA: begin
                if (cnt_zero_s) begin
`ifdef PISO_TX_PARITY_EN
                    state_nxt_s = ST_PAR;
`else
                    state_nxt_s = ST_IDLE;
`endif
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef PISO_TX_PARITY_EN
            ST_PAR:  state_nxt_s = ST_IDLE;
`endif
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output logic; so/done are computed one cycle ahead so both leave flops.
    always_comb begin
        cnt_load_s = (state_r == ST_START);
        cnt_dec_s  = (state_r == ST_DATA);
        shift_s    = (state_nxt_s == ST_DATA);
        so_nxt_s   = LINE_IDLE;
        case (state_nxt_s)
            ST_IDLE:  so_nxt_s = LINE_IDLE;
            ST_START: so_nxt_s = LINE_START;
            ST_DATA:  so_nxt_s = shift_r[WIDTH-1];
`ifdef PISO_TX_PARITY_EN
            ST_PAR:   so_nxt_s = par_r;
`endif
            default:  so_nxt_s = LINE_IDLE;
        endcase
`ifdef PISO_TX_PARITY_EN
        done_nxt_s = (state_r == ST_DATA) && (cnt_s == {CW{1'b0}});
`else
        done_nxt_s = (state_r == ST_DATA) && (cnt_s == CNT_ONE);
`endif
    end

    // Shift register and registered serial outputs.
    always_ff @(posedge clk) begin
        if (clear) begin
            shift_r <= {WIDTH{1'b0}};
            so_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                shift_r <= din;
            end else if (shift_s) begin
                shift_r <= {shift_r[WIDTH-2:0], 1'b0};
            end else begin
                shift_r <= shift_r;
            end
            so_r   <= so_nxt_s;
            done_r <= done_nxt_s;
        end
    end

`ifdef PISO_TX_PARITY_EN
    // Parity captured with the word so later changes on din cannot affect it.
    always_ff @(posedge clk) begin
        if (clear) begin
            par_r <= 1'b0;
        end else if (accept_s) begin
            par_r <= even_parity32(32'(din));
        end else begin
            par_r <= par_r;
        end
    end
`endif

    assign ready = (state_r == ST_IDLE) && !clear;
    assign busy  = (state_r != ST_IDLE);
    assign so    = so_r;
    assign done  = done_r;

endmodule

// File: tb/tb_piso_tx_32bit.sv
// Scoreboard bench for piso_tx_32bit (32-bit instance plus an 8-bit instance).
module tb_piso_tx_32bit;

`ifdef PISO_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clear;
    logic        load;
    logic [31:0] din;
    logic        ready, so, busy, done;
    logic        load8;
    logic [7:0]  din8;
    logic        ready8, so8, busy8, done8;

    int checks = 0;
    int fails  = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic so;
        logic done;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    piso_tx_32bit #(.WIDTH(32)) dut (
        .clk(clk), .clear(clear), .din(din), .load(load),
        .ready(ready), .so(so), .busy(busy), .done(done)
    );

    piso_tx_32bit #(.WIDTH(8)) dut8 (
        .clk(clk), .clear(clear), .din(din8), .load(load8),
        .ready(ready8), .so(so8), .busy(busy8), .done(done8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [31:0] w);
        exp_q.push_back('{1'b1, 1'b0});
        for (int i = 31; i >= 0; i--) begin
            exp_q.push_back('{w[i], logic'((i == 0) && !PAR_EN)});
        end
        if (PAR_EN) begin
            exp_q.push_back('{^w, 1'b1});
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL ready_timeout: ready still low after 200 cycles at %0t", $time);
        end
    endtask

    task automatic send(input logic [31:0] w);
        bit ok;
        wait_ready(ok);
        din  = w;
        load = 1'b1;
        push_frame(w);
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Monitor: every busy cycle consumes one expected bit; idle cycles must be quiet.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_bit: busy with nothing queued, so=%0b at %0t", so, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("so_bit", 32'(so), 32'(mon_e.so));
                    chk("done_bit", 32'(done), 32'(mon_e.done));
                end
            end else begin
                chk("idle_so", 32'(so), 32'd0);
                chk("idle_done", 32'(done), 32'd0);
            end
        end
    end

    initial begin
        int          k;
        int          g;
        int          t;
        int          nb;
        int          dn;
        int          dpos;
        bit          ok;
        logic [9:0]  seq;
        logic [31:0] w;

        clear = 1'b1;
        load  = 1'b1;
        din   = 32'hDEAD_BEEF;
        load8 = 1'b0;
        din8  = 8'h00;

        // Reset held three cycles with load high: nothing may start.
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_busy", 32'(busy), 32'd0);
            chk("reset_ready", 32'(ready), 32'd0);
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
        load  = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(ready), 32'd1);
        chk("busy_after_reset", 32'(busy), 32'd0);

        // Single word and accept-to-ready spacing.
        send(32'hA5A5_0F0F);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ready && k < 100);
        chk("accept_to_ready", 32'(k), PAR_EN ? 32'd35 : 32'd34);

        // Parity vectors: 0x1 gives parity 1, 0x3 gives parity 0.
        send(32'h0000_0001);
        send(32'h0000_0003);

        // Back-to-back with load held high; din changes right after the first acceptance.
        wait_ready(ok);
        din  = 32'hFFFF_FFFF;
        load = 1'b1;
        push_frame(32'hFFFF_FFFF);
        push_frame(32'h0000_0000);
        @(posedge clk);
        #1;
        din = 32'h0000_0000;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 100);
        g = 0;
        while (!busy && t < 100) begin
            g++;
            @(negedge clk);
            t++;
        end
        load = 1'b0;
        chk("b2b_gap", 32'(g), 32'd1);

        // Clear during DATA cycle 10: frame abandoned, no done pulse.
        wait_ready(ok);
        w    = 32'h1234_5678;
        din  = w;
        load = 1'b1;
        exp_q.push_back('{1'b1, 1'b0});
        for (int i = 31; i >= 22; i--) begin
            exp_q.push_back('{w[i], 1'b0});
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clear_busy", 32'(busy), 32'd0);
        chk("clear_so", 32'(so), 32'd0);
        chk("clear_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("clear_queue_drained", 32'(exp_q.size()), 32'd0);
        send(32'h0F0F_A5A5);
        wait_ready(ok);

        // WIDTH=8 instance, din=0x81.
        din8  = 8'h81;
        load8 = 1'b1;
        @(posedge clk);
        #1;
        load8 = 1'b0;
        seq  = 10'd0;
        nb   = 0;
        dn   = 0;
        dpos = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy8) begin
                seq = {seq[8:0], so8};
                nb++;
                if (done8) begin
                    dn++;
                    dpos = nb;
                end
            end
        end
        chk("w8_busy_cycles", 32'(nb), PAR_EN ? 32'd10 : 32'd9);
        chk("w8_bits", 32'(seq), PAR_EN ? 32'h302 : 32'h181);
        chk("w8_done_count", 32'(dn), 32'd1);
        chk("w8_done_pos", 32'(dpos), PAR_EN ? 32'd10 : 32'd9);
        chk("w8_ready_after", 32'(ready8), 32'd1);
        chk("w8_so_idle", 32'(so8), 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
